// File: rtl/anita3_deadtime_generator.sv
// Deadtime level generator for the 250 MHz trigger domain: ring-ordered buffer occupancy,
// post-trigger holdoff, run disable and per-PPS lost-trigger count. Optional macro: DEADGEN_EXT_BUSY_EN.
module anita3_deadtime_generator #(
    parameter int NBUF    = 4,
    parameter int HOLDOFF = 16,
    parameter int LOSTW   = 16
) (
    input  logic                    clk250_i,
    input  logic                    rst_n_i,
    input  logic                    trig_i,
    input  logic                    clear_i,
    input  logic [$clog2(NBUF)-1:0] clear_buf_i,
    input  logic                    disable_i,
    input  logic                    pps_i,
`ifdef DEADGEN_EXT_BUSY_EN
    input  logic                    ext_busy_i,
`endif
    output logic                    dead_o,
    output logic [$clog2(NBUF)-1:0] wr_buf_o,
    output logic [NBUF-1:0]         occupied_o,
    output logic                    trig_accept_o,
    output logic [LOSTW-1:0]        lost_o
);

    localparam int PW  = $clog2(NBUF);
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_LIVE     = 2'd0,
        ST_HOLDOFF  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DISABLED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NBUF-1:0]  occupied_q, occupied_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [LOSTW-1:0] lost_cnt_q, lost_cnt_d;
    logic [LOSTW-1:0] lost_q, lost_d;
    logic             accept_q, accept_d;
    logic             dead_q, dead_d;
    logic             block_s;
    logic             lost_ev_s;

    // Leaving dead time: a disable beats a blocked ring, which beats going live.
    function automatic state_t exit_state(input logic blk, input logic next_occupied);
        state_t st;
        if (blk) begin
            st = ST_DISABLED;
        end else if (next_occupied) begin
            st = ST_FULL;
        end else begin
            st = ST_LIVE;
        end
        return st;
    endfunction

`ifdef DEADGEN_EXT_BUSY_EN
    assign block_s = disable_i | ext_busy_i;
`else
    assign block_s = disable_i;
`endif

    // Next-state, occupancy and holdoff counter.
    always_comb begin
        state_d    = state_q;
        occupied_d = occupied_q;
        wr_ptr_d   = wr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        accept_d   = 1'b0;

        if (clear_i) begin
            occupied_d[clear_buf_i] = 1'b0;
        end else begin
            occupied_d = occupied_q;
        end

        case (state_q)
            ST_LIVE: begin
                if (trig_i && !block_s) begin
                    accept_d             = 1'b1;
                    // Applied after the clear so a stale clear of this index loses.
                    occupied_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d             = wr_ptr_q + PW'(1);
                    if (HOLDOFF == 0) begin
                        hold_cnt_d = {HCW{1'b0}};
                        state_d    = exit_state(block_s, occupied_d[wr_ptr_d]);
                    end else begin
                        hold_cnt_d = HCW'(HOLDOFF - 1);
                        state_d    = ST_HOLDOFF;
                    end
                end else if (block_s) begin
                    state_d = ST_DISABLED;
                end else begin
                    state_d = ST_LIVE;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == {HCW{1'b0}}) begin
                    state_d = exit_state(block_s, occupied_q[wr_ptr_q]);
                end else begin
                    hold_cnt_d = hold_cnt_q - HCW'(1);
                    state_d    = ST_HOLDOFF;
                end
            end
            ST_FULL: begin
                // Only freeing the buffer at wr_ptr unblocks; the ring never skips.
                if (block_s) begin
                    state_d = ST_DISABLED;
                end else if (!occupied_q[wr_ptr_q]) begin
                    state_d = ST_LIVE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DISABLED: begin
                if (!block_s) begin
                    state_d = occupied_q[wr_ptr_q] ? ST_FULL : ST_LIVE;
                end else begin
                    state_d = ST_DISABLED;
                end
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        dead_d = (state_d != ST_LIVE);
    end

    assign lost_ev_s = trig_i & ~accept_d;

    // Lost-trigger counter with PPS snapshot; a coincident lost trigger starts the new second at 1.
    always_comb begin
        if (pps_i) begin
            lost_d     = lost_cnt_q;
            lost_cnt_d = lost_ev_s ? LOSTW'(1) : {LOSTW{1'b0}};
        end else begin
            lost_d = lost_q;
            if (lost_ev_s && (lost_cnt_q != {LOSTW{1'b1}})) begin
                lost_cnt_d = lost_cnt_q + LOSTW'(1);
            end else begin
                lost_cnt_d = lost_cnt_q;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_DISABLED;
            occupied_q <= {NBUF{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            hold_cnt_q <= {HCW{1'b0}};
            lost_cnt_q <= {LOSTW{1'b0}};
            lost_q     <= {LOSTW{1'b0}};
            accept_q   <= 1'b0;
            dead_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            occupied_q <= occupied_d;
            wr_ptr_q   <= wr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            lost_q     <= lost_d;
            accept_q   <= accept_d;
            dead_q     <= dead_d;
        end
    end

    assign dead_o        = dead_q;
    assign wr_buf_o      = wr_ptr_q;
    assign occupied_o    = occupied_q;
    assign trig_accept_o = accept_q;
    assign lost_o        = lost_q;

endmodule
